fifo_ctrl_fsm: RTL and testbench

- Parametrised control state machine for the switch's FIFO bank: RESET/INIT/IDLE/ACTIVE sequencing plus an ERROR state.
- Latches full/empty thresholds during INIT and validates them.
- Generates registered per-FIFO almost-full and almost-empty flags and a global pause.
- Defers re-initialisation requested while traffic is in flight until the bank drains.
- Sits between the top-level configuration inputs and the NUM_FIFOS class/destination FIFOs.

---
 rtl/fifo_ctrl_fsm_pkg.sv | 14 +
 rtl/fifo_threshold_cmp.sv | 17 +
 rtl/fifo_ctrl_fsm.sv | 117 +++++++++++
 tb/tb_fifo_ctrl_fsm.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_ctrl_fsm_pkg.sv
// Shared state encoding for the FIFO bank controller and its status consumers.
package fifo_ctrl_fsm_pkg;

   localparam int ST_W = 3;

   typedef enum logic [ST_W-1:0] {
      ST_RESET  = 3'd0,
      ST_INIT   = 3'd1,
      ST_IDLE   = 3'd2,
      ST_ACTIVE = 3'd3,
      ST_ERROR  = 3'd4
   } state_t;

endpackage

// File: rtl/fifo_threshold_cmp.sv
// Combinational almost-full / almost-empty compare for one FIFO occupancy.
module fifo_threshold_cmp #(
   parameter int PTR   = 3,
   parameter int OCC_W = PTR + 1
) (
   input  logic [OCC_W-1:0] i_occ,
   input  logic [PTR-1:0]   i_full_th,
   input  logic [PTR-1:0]   i_empty_th,
   output logic             o_almost_full,
   output logic             o_almost_empty
);

   // Thresholds are zero-extended so a completely full FIFO (2^PTR) still compares correctly.
   assign o_almost_full  = (i_occ >= OCC_W'(i_full_th));
   assign o_almost_empty = (i_occ <= OCC_W'(i_empty_th));

endmodule

// File: rtl/fifo_ctrl_fsm.sv
// FIFO bank control FSM: threshold configuration, drain-deferred re-init and registered flags.
module fifo_ctrl_fsm
   import fifo_ctrl_fsm_pkg::*;
#(
   parameter int NUM_FIFOS = 9,
   parameter int PTR       = 3,
   parameter int OCC_W     = PTR + 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       init,
   input  logic [PTR-1:0]             full_threshold,
   input  logic [PTR-1:0]             empty_threshold,
   input  logic [NUM_FIFOS-1:0]       fifos_empty,
   input  logic [NUM_FIFOS*OCC_W-1:0] fifos_occupancy,
   output logic [PTR-1:0]             fifos_full_threshold,
   output logic [PTR-1:0]             fifos_empty_threshold,
   output logic [NUM_FIFOS-1:0]       almost_full,
   output logic [NUM_FIFOS-1:0]       almost_empty,
   output logic                       pause,
   output logic                       idle,
   output logic                       error,
   output logic                       init_pending,
   output logic [ST_W-1:0]            state
);

   state_t               r_state, w_nxt_state;
   logic [PTR-1:0]       r_full_th, r_empty_th;
   logic [NUM_FIFOS-1:0] r_af, r_ae, w_af_raw, w_ae_raw, w_af_nxt, w_ae_nxt;
   logic                 r_pause, r_idle, r_error, r_pend, w_nxt_pend, w_latch;
   logic                 w_all_empty, w_valid, w_flag_en;

   genvar g;
   generate
      for (g = 0; g < NUM_FIFOS; g++) begin : g_cmp
         fifo_threshold_cmp #(.PTR(PTR), .OCC_W(OCC_W)) u_cmp (
            .i_occ          (fifos_occupancy[g*OCC_W +: OCC_W]),
            .i_full_th      (r_full_th),
            .i_empty_th     (r_empty_th),
            .o_almost_full  (w_af_raw[g]),
            .o_almost_empty (w_ae_raw[g])
         );
      end
   endgenerate

   assign w_all_empty = &fifos_empty;
   assign w_valid     = (r_full_th != '0) && (r_empty_th < r_full_th);

   always_comb begin
      w_nxt_state = r_state;
      w_nxt_pend  = r_pend;
      w_latch     = 1'b0;
      case (r_state)
         ST_RESET: w_nxt_state = ST_INIT;
         ST_INIT: begin
            if (init) w_latch = 1'b1;
            else      w_nxt_state = w_valid ? ST_IDLE : ST_ERROR;
         end
         ST_IDLE: begin
            if (init)              w_nxt_state = ST_INIT;
            else if (!w_all_empty) w_nxt_state = ST_ACTIVE;
         end
         ST_ACTIVE: begin
            // Re-init is held off until every FIFO has drained.
            if (w_all_empty) begin
               w_nxt_state = (r_pend || init) ? ST_INIT : ST_IDLE;
               w_nxt_pend  = 1'b0;
            end else if (init) begin
               w_nxt_pend  = 1'b1;
            end
         end
         ST_ERROR: if (init) w_nxt_state = ST_INIT;
         default:  w_nxt_state = ST_RESET;
      endcase
   end

   assign w_flag_en = (w_nxt_state == ST_IDLE) || (w_nxt_state == ST_ACTIVE);
   assign w_af_nxt  = w_flag_en ? w_af_raw : '0;
   assign w_ae_nxt  = w_flag_en ? w_ae_raw : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= ST_RESET;
         r_full_th  <= '0;
         r_empty_th <= '0;
         r_af       <= '0;
         r_ae       <= '0;
         r_pause    <= 1'b0;
         r_idle     <= 1'b0;
         r_error    <= 1'b0;
         r_pend     <= 1'b0;
      end else begin
         r_state <= w_nxt_state;
         if (w_latch) begin
            r_full_th  <= full_threshold;
            r_empty_th <= empty_threshold;
         end
         r_af    <= w_af_nxt;
         r_ae    <= w_ae_nxt;
         r_pause <= |w_af_nxt;
         r_idle  <= (w_nxt_state == ST_IDLE);
         r_error <= (w_nxt_state == ST_ERROR);
         r_pend  <= w_nxt_pend;
      end
   end

   assign fifos_full_threshold  = r_full_th;
   assign fifos_empty_threshold = r_empty_th;
   assign almost_full           = r_af;
   assign almost_empty          = r_ae;
   assign pause                 = r_pause;
   assign idle                  = r_idle;
   assign error                 = r_error;
   assign init_pending          = r_pend;
   assign state                 = r_state;

endmodule

// File: tb/tb_fifo_ctrl_fsm.sv
// Directed bench: behavioural model compared every cycle plus literal spot checks.
module tb_fifo_ctrl_fsm;

   logic        clk;
   logic        reset;
   logic        init;
   logic [2:0]  full_th, empty_th;
   logic [8:0]  fifos_empty;
   logic [35:0] occ;
   logic [2:0]  o_fth, o_eth, o_state;
   logic [8:0]  o_af, o_ae;
   logic        o_pause, o_idle, o_error, o_pend;

   logic        init1;
   logic [3:0]  full_th1, empty_th1, fifos_empty1, o1_fth, o1_eth, o1_af, o1_ae;
   logic [19:0] occ1;
   logic [2:0]  o1_state;
   logic        o1_pause, o1_idle, o1_error, o1_pend;

   int checks = 0;
   int errors = 0;
   bit run = 0;

   fifo_ctrl_fsm u0 (
      .clk(clk), .reset(reset), .init(init),
      .full_threshold(full_th), .empty_threshold(empty_th),
      .fifos_empty(fifos_empty), .fifos_occupancy(occ),
      .fifos_full_threshold(o_fth), .fifos_empty_threshold(o_eth),
      .almost_full(o_af), .almost_empty(o_ae), .pause(o_pause),
      .idle(o_idle), .error(o_error), .init_pending(o_pend), .state(o_state)
   );

   fifo_ctrl_fsm #(.NUM_FIFOS(4), .PTR(4)) u1 (
      .clk(clk), .reset(reset), .init(init1),
      .full_threshold(full_th1), .empty_threshold(empty_th1),
      .fifos_empty(fifos_empty1), .fifos_occupancy(occ1),
      .fifos_full_threshold(o1_fth), .fifos_empty_threshold(o1_eth),
      .almost_full(o1_af), .almost_empty(o1_ae), .pause(o1_pause),
      .idle(o1_idle), .error(o1_error), .init_pending(o1_pend), .state(o1_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Model: states as plain integers 0..4, following the behavioural rules directly.
   int         m_st = 0;
   bit         m_pend = 0;
   int         m_fth = 0, m_eth = 0;
   logic [8:0] m_af = '0, m_ae = '0;

   always @(posedge clk or posedge reset) begin
      int  nst, nf, ne, o;
      bit  np, alle;
      if (reset) begin
         m_st <= 0; m_pend <= 0; m_fth <= 0; m_eth <= 0; m_af <= '0; m_ae <= '0;
      end else begin
         nst = m_st; np = m_pend; nf = m_fth; ne = m_eth;
         alle = (fifos_empty == 9'h1FF);
         if (m_st == 0) nst = 1;
         else if (m_st == 1) begin
            if (init) begin nf = full_th; ne = empty_th; end
            else nst = (m_fth != 0 && m_eth < m_fth) ? 2 : 4;
         end else if (m_st == 2) begin
            if (init) nst = 1;
            else if (!alle) nst = 3;
         end else if (m_st == 3) begin
            if (alle) begin nst = (m_pend || init) ? 1 : 2; np = 0; end
            else if (init) np = 1;
         end else if (m_st == 4) begin
            if (init) nst = 1;
         end
         for (int i = 0; i < 9; i++) begin
            o = occ[i*4 +: 4];
            m_af[i] <= (nst == 2 || nst == 3) && (o >= m_fth);
            m_ae[i] <= (nst == 2 || nst == 3) && (o <= m_eth);
         end
         m_st <= nst; m_pend <= np; m_fth <= nf; m_eth <= ne;
      end
   end

   always @(negedge clk) begin
      if (run && !reset) begin
         chk("state", 32'(o_state), 32'(m_st));
         chk("full_th", 32'(o_fth), 32'(m_fth));
         chk("empty_th", 32'(o_eth), 32'(m_eth));
         chk("almost_full", 32'(o_af), 32'(m_af));
         chk("almost_empty", 32'(o_ae), 32'(m_ae));
         chk("pause", 32'(o_pause), 32'(|m_af));
         chk("idle", 32'(o_idle), 32'(m_st == 2));
         chk("error", 32'(o_error), 32'(m_st == 4));
         chk("init_pending", 32'(o_pend), 32'(m_pend));
      end
   end

   initial begin
      reset = 1'b1; init = 1'b1; full_th = 3'd6; empty_th = 3'd1;
      fifos_empty = 9'h1FF; occ = '0;
      init1 = 1'b1; full_th1 = 4'd15; empty_th1 = 4'd0;
      fifos_empty1 = 4'b0100; occ1 = {5'd16, 5'd0, 5'd5, 5'd5};
      #1;
      chk("reset_state", 32'(o_state), 32'd0);
      chk("reset_flags", 32'({o_af, o_ae, o_pause, o_idle, o_error, o_pend}), 32'd0);
      tick(); tick();
      reset = 1'b0; run = 1'b1;
      chk("rst_release_state", 32'(o_state), 32'd0);
      tick(); chk("st_a", 32'(o_state), 32'd1);
      tick(); tick();
      init = 1'b0; init1 = 1'b0;
      tick();
      chk("cfg_state", 32'(o_state), 32'd2);
      chk("cfg_fth", 32'(o_fth), 32'd6);
      chk("cfg_eth", 32'(o_eth), 32'd1);
      chk("cfg_idle", 32'(o_idle), 32'd1);
      chk("u1_state_idle", 32'(o1_state), 32'd2);
      chk("u1_af", 32'(o1_af), 32'h8);
      chk("u1_ae", 32'(o1_ae), 32'h4);
      tick();
      chk("u1_state_active", 32'(o1_state), 32'd3);
      chk("u1_pause", 32'(o1_pause), 32'd1);

      // Invalid pair (empty == full) lands in ERROR, then recover.
      init = 1'b1; full_th = 3'd2; empty_th = 3'd2;
      tick(); tick();
      init = 1'b0; tick();
      chk("err_state", 32'(o_state), 32'd4);
      chk("err_flag", 32'(o_error), 32'd1);
      chk("err_idle", 32'(o_idle), 32'd0);
      init = 1'b1; full_th = 3'd5; empty_th = 3'd0;
      tick(); chk("rec_init", 32'(o_state), 32'd1);
      tick(); init = 1'b0; tick();
      chk("rec_idle", 32'(o_state), 32'd2);

      init = 1'b1; full_th = 3'd6; empty_th = 3'd1;
      tick(); tick(); init = 1'b0; tick();

      // Traffic: init and non-empty together in IDLE -> init wins.
      init = 1'b1; fifos_empty = 9'h1FE; occ[3:0] = 4'd6;
      tick(); chk("init_wins", 32'(o_state), 32'd1);
      init = 1'b0; tick();
      tick();
      chk("act_state", 32'(o_state), 32'd3);
      chk("act_af", 32'(o_af), 32'h001);
      chk("act_ae", 32'(o_ae), 32'h1FE);
      chk("act_pause", 32'(o_pause), 32'd1);
      occ[3:0] = 4'd1; tick();
      chk("drop_af", 32'(o_af), 32'h000);
      chk("drop_ae", 32'(o_ae), 32'h1FF);
      occ[3:0] = 4'd8; tick();
      chk("full_occ_af", 32'(o_af), 32'h001);

      // Deferred re-init.
      init = 1'b1; tick();
      chk("pend_set", 32'(o_pend), 32'd1);
      chk("pend_state", 32'(o_state), 32'd3);
      init = 1'b0; tick(); tick();
      fifos_empty = 9'h1FF; tick();
      chk("drain_state", 32'(o_state), 32'd1);
      chk("drain_pend", 32'(o_pend), 32'd0);
      chk("drain_flags", 32'(o_af | o_ae), 32'd0);

      // Async reset mid-ACTIVE.
      tick();
      fifos_empty = 9'h1FE; occ[3:0] = 4'd7; tick();
      chk("pre_rst_state", 32'(o_state), 32'd3);
      #1 reset = 1'b1;
      #1;
      chk("arst_state", 32'(o_state), 32'd0);
      chk("arst_th", 32'({o_fth, o_eth}), 32'd0);
      chk("arst_flags", 32'({o_af, o_ae, o_pause, o_pend}), 32'd0);
      tick(); tick();
      reset = 1'b0;
      tick(); tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
